// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command front-end:
//   - ALU select encoding (signedness lives only in the op choice)
//   - sequencer FSM state encoding
//   - command record layout {use_prev, tag, sel, b, a}, MSB to LSB
// No ports; imported by alu_cmd_sequencer and cmd_fifo users.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] ALU_ADD  = 3'd0;
    localparam logic [SEL_W-1:0] ALU_ADDU = 3'd1;
    localparam logic [SEL_W-1:0] ALU_SUB  = 3'd2;
    localparam logic [SEL_W-1:0] ALU_SUBU = 3'd3;
    localparam logic [SEL_W-1:0] ALU_AND  = 3'd4;
    localparam logic [SEL_W-1:0] ALU_OR   = 3'd5;
    localparam logic [SEL_W-1:0] ALU_SRA  = 3'd6;
    localparam logic [SEL_W-1:0] ALU_SRL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_OUT = 2'd2
    } state_e;

    // Bit width of a packed command record {use_prev, tag, sel, b, a}.
    function automatic int unsigned cmd_rec_w(input int unsigned width,
                                              input int unsigned tag_w);
        return 2 * width + SEL_W + tag_w + 1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ----------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO holding packed ALU command records.
// Ports:
//   clk, rst_n       clock / asynchronous active-low reset
//   i_push, i_data   write strobe and record (ignored when full)
//   i_pop            read strobe (ignored when empty)
//   o_data           head record (valid while !o_empty)
//   o_count          number of stored entries, 0..DEPTH
//   o_full, o_empty  status flags derived from o_count
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [DW-1:0]                i_data,
    input  logic                         i_pop,
    output logic [DW-1:0]                o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer
// Command front-end for a combinational ALU. Commands are queued in a FIFO,
// issued as registered operands, and the ALU result is captured one cycle
// later and offered on a valid/ready result port together with its tag.
// A command with use_prev set takes operand a from the last captured result.
// Ports:
//   clk, rst_n                       clock / asynchronous active-low reset
//   cmd_valid, cmd_ready             command handshake (cmd_ready = !full)
//   cmd_a, cmd_b, cmd_sel            command operands and ALU op
//   cmd_use_prev, cmd_tag            chaining flag and user tag
//   alu_a, alu_b, alu_sel            registered operands to the ALU
//   alu_out                          combinational ALU result
//   res_valid, res_ready             result handshake
//   res_data, res_tag                captured result and its tag
//   occupancy                        FIFO entry count
//   busy                             FSM not idle or FIFO not empty
// ----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [WIDTH-1:0]            cmd_a,
    input  logic [WIDTH-1:0]            cmd_b,
    input  logic [2:0]                  cmd_sel,
    input  logic                        cmd_use_prev,
    input  logic [TAG_W-1:0]            cmd_tag,
    output logic [WIDTH-1:0]            alu_a,
    output logic [WIDTH-1:0]            alu_b,
    output logic [2:0]                  alu_sel,
    input  logic [WIDTH-1:0]            alu_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [WIDTH-1:0]            res_data,
    output logic [TAG_W-1:0]            res_tag,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic                        busy
);

    localparam int unsigned REC_W = cmd_rec_w(WIDTH, TAG_W);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             use_prev;
        logic [TAG_W-1:0] tag;
        logic [2:0]       sel;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] a;
    } cmd_rec_t;

    state_e           r_state;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_sel;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_last;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [TAG_W-1:0] r_res_tag;

    cmd_rec_t         w_push_rec;
    cmd_rec_t         w_head;
    logic [REC_W-1:0] w_fifo_dout;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_next_a;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;

    always_comb begin
        w_push_rec          = '0;
        w_push_rec.use_prev = cmd_use_prev;
        w_push_rec.tag      = cmd_tag;
        w_push_rec.sel      = cmd_sel;
        w_push_rec.b        = cmd_b;
        w_push_rec.a        = cmd_a;
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (REC_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_rec),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head = cmd_rec_t'(w_fifo_dout);

    // Pop happens from IDLE, or from WAIT_OUT in the same edge that releases
    // the held result; either way the previous result is already in r_last.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || ((r_state == WAIT_OUT) && res_ready));

    assign w_next_a = w_head.use_prev ? r_last : w_head.a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_tag       <= '0;
            r_last      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_alu_a   <= w_next_a;
                        r_alu_b   <= w_head.b;
                        r_alu_sel <= w_head.sel;
                        r_tag     <= w_head.tag;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands were registered last edge, so alu_out has settled.
                    r_res_data  <= alu_out;
                    r_res_tag   <= r_tag;
                    r_last      <= alu_out;
                    r_res_valid <= 1'b1;
                    r_state     <= WAIT_OUT;
                end
                WAIT_OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_a   <= w_next_a;
                            r_alu_b   <= w_head.b;
                            r_alu_sel <= w_head.sel;
                            r_tag     <= w_head.tag;
                            r_state   <= EXEC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_tag   = r_res_tag;
    assign occupancy = w_count;
    assign busy      = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Drives alu_cmd_sequencer with a behavioural 32-bit ALU attached. Each
// accepted command pushes its expected {data, tag} into a queue computed from
// the command stream; a monitor pops and compares on every result handshake.
// ----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [WIDTH-1:0]   cmd_a;
    logic [WIDTH-1:0]   cmd_b;
    logic [2:0]         cmd_sel;
    logic               cmd_use_prev;
    logic [TAG_W-1:0]   cmd_tag;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [2:0]         alu_sel;
    logic [WIDTH-1:0]   alu_out;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [WIDTH-1:0]   res_data;
    logic [TAG_W-1:0]   res_tag;
    logic [OCC_W-1:0]   occupancy;
    logic               busy;

    alu_cmd_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_sel      (cmd_sel),
        .cmd_use_prev (cmd_use_prev),
        .cmd_tag      (cmd_tag),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_out      (alu_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_tag      (res_tag),
        .occupancy    (occupancy),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (sel)
            ALU_ADD, ALU_ADDU: return a + b;
            ALU_SUB, ALU_SUBU: return a - b;
            ALU_AND:           return a & b;
            ALU_OR:            return a | b;
            ALU_SRA:           return WIDTH'($signed(a) >>> b[4:0]);
            ALU_SRL:           return a >> b[4:0];
            default:           return '0;
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_sel, alu_a, alu_b);

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             exp_q[$];
    int               hs_q[$];
    logic [WIDTH-1:0] m_last = '0;
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               rr_mode = 0;
    logic             mon_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: results follow command order, chaining through m_last.
    task automatic model_push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [2:0] sel, input logic up,
                              input logic [TAG_W-1:0] tag);
        logic [WIDTH-1:0] r;
        exp_t e;
        r = alu_fn(sel, up ? m_last : a, b);
        m_last = r;
        e.data = r;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] sel, input logic up, input logic [TAG_W-1:0] tag);
        bit done = 1'b0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_sel = sel;
        cmd_use_prev = up;
        cmd_tag = tag;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready && rst_n) begin
                model_push(a, b, sel, up, tag);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!done) fail("push_timeout");
    endtask

    task automatic push_rand(input logic [TAG_W-1:0] tag, input logic up);
        logic [WIDTH-1:0] b;
        b = ($urandom_range(1) == 0) ? WIDTH'($urandom_range(31)) : WIDTH'($urandom());
        push(WIDTH'($urandom()), b, 3'($urandom_range(7)), up, tag);
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 1000 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        if (exp_q.size() != 0 || busy) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    // Sole driver of res_ready: 0 = low, 1 = high, otherwise random.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: compare on every result handshake; a held result must stay valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_hold = 1'b0;
            end else begin
                if (mon_hold) chk("hold_valid", 64'(res_valid), 1);
                if (res_valid && res_ready) begin
                    hs_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got data 0x%0h tag %0d, expected none",
                                 res_data, res_tag);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", 64'(res_data), 64'(e.data));
                        chk("res_tag", 64'(res_tag), 64'(e.tag));
                    end
                end
                mon_hold = res_valid && !res_ready;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_sel = '0;
        cmd_use_prev = 1'b0;
        cmd_tag = '0;

        // Reset held 3 cycles.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 1);
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_occupancy", 64'(occupancy), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_alu_a", 64'(alu_a), 0);
        chk("rst_res_data", 64'(res_data), 0);

        // Single command latency.
        @(posedge clk);
        #1;
        push(32'd10, 32'hFFFF_FFFE, ALU_ADD, 1'b0, 4'd3);
        @(negedge clk);
        chk("lat_occ_e0", 64'(occupancy), 1);
        chk("lat_valid_e0", 64'(res_valid), 0);
        @(negedge clk);
        chk("lat_alu_sel_e1", 64'(alu_sel), 0);
        chk("lat_alu_a_e1", 64'(alu_a), 10);
        chk("lat_alu_b_e1", 64'(alu_b), 64'h0000_0000_FFFF_FFFE);
        chk("lat_occ_e1", 64'(occupancy), 0);
        chk("lat_valid_e1", 64'(res_valid), 0);
        chk("lat_busy_e1", 64'(busy), 1);
        @(negedge clk);
        chk("lat_valid_e2", 64'(res_valid), 1);
        chk("lat_data_e2", 64'(res_data), 8);
        chk("lat_tag_e2", 64'(res_tag), 3);
        rr_mode = 1;
        wait_drain();

        // Chaining: second result must be (10-2) >> 1 = 4.
        push(32'd10, 32'd2, ALU_SUB, 1'b0, 4'd5);
        push(32'h0000_DEAD, 32'd1, ALU_SRL, 1'b1, 4'd6);
        wait_drain();
        chk("chain_last", 64'(m_last), 4);

        // Backpressure: DEPTH+1 absorbed, then one result per 2 cycles.
        rr_mode = 0;
        @(posedge clk);
        #1;
        for (int t = 0; t < 5; t++) push_rand(4'(t), 1'b0);
        fork
            push_rand(4'd5, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_cmd_ready", 64'(cmd_ready), 0);
                    chk("bp_occupancy", 64'(occupancy), 4);
                end
                hs_q.delete();
                @(posedge clk);
                #1 rr_mode = 1;
            end
        join
        wait_drain();
        chk("bp_count", 64'(hs_q.size()), 6);
        for (int i = 1; i < hs_q.size(); i++) chk("bp_gap", 64'(hs_q[i] - hs_q[i-1]), 2);

        // Full refills with a release while a push is pending; pointers wrap.
        for (int r = 0; r < 3; r++) begin
            rr_mode = 0;
            @(posedge clk);
            #1;
            for (int t = 0; t < 5; t++) push_rand(4'(t + 8), 1'($urandom_range(1)));
            @(negedge clk);
            chk("full_occ", 64'(occupancy), 4);
            chk("full_cmd_ready", 64'(cmd_ready), 0);
            chk("full_res_valid", 64'(res_valid), 1);
            fork
                push_rand(4'd15, 1'b1);
                begin
                    @(posedge clk);
                    #1 rr_mode = 1;
                    @(posedge clk);
                    #1 rr_mode = 0;
                end
            join
            @(negedge clk);
            chk("refill_occ", 64'(occupancy), 4);
            chk("refill_cmd_ready", 64'(cmd_ready), 0);
            rr_mode = 1;
            wait_drain();
        end

        // Asynchronous reset mid-flight.
        rr_mode = 0;
        @(posedge clk);
        #1;
        for (int t = 0; t < 4; t++) push_rand(4'(t), 1'b0);
        @(negedge clk);
        chk("mid_res_valid", 64'(res_valid), 1);
        chk("mid_occ", 64'(occupancy), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_res_valid", 64'(res_valid), 0);
        chk("arst_occ", 64'(occupancy), 0);
        chk("arst_cmd_ready", 64'(cmd_ready), 1);
        chk("arst_busy", 64'(busy), 0);
        exp_q.delete();
        m_last = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rr_mode = 1;
        push(WIDTH'($urandom()), 32'd5, ALU_ADDU, 1'b1, 4'd9);
        wait_drain();
        chk("arst_chain_last", 64'(m_last), 5);

        // Randomised traffic with random backpressure.
        rr_mode = 2;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            push_rand(4'($urandom_range(15)), ($urandom_range(3) == 0));
        end
        wait_drain();
        chk("final_queue_empty", 64'(exp_q.size()), 0);
        chk("final_occ", 64'(occupancy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command front-end that sits directly upstream of the combinational 32-bit ALU (operands a and b, 3-bit sel, result out_data).
- Buffers ALU commands in a small FIFO and drives registered operands into the ALU.
- Captures the ALU result one cycle later and presents it with a tag on a valid/ready result port.
- Supports result chaining: a command may replace operand a with the previous result.

Parameters:
WIDTH, 32, operand/result width (must match the ALU)
DEPTH, 4, command FIFO entries; power of 2, >= 2
TAG_W, 4, width of the user tag carried from command to result

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_a  in  WIDTH  operand a
cmd_b  in  WIDTH  operand b
cmd_sel  in  3  ALU op, encoding from alu_pkg
cmd_use_prev  in  1  substitute last_result for cmd_a
cmd_tag  in  TAG_W  user tag
alu_a  out  WIDTH  registered operand a to ALU
alu_b  out  WIDTH  registered operand b to ALU
alu_sel  out  3  registered op to ALU
alu_out  in  WIDTH  ALU combinational result
res_valid  out  1  result held
res_ready  in  1  consumer accepts
res_data  out  WIDTH  captured result
res_tag  out  TAG_W  tag of the command that produced res_data
occupancy  out  $clog2(DEPTH+1)  FIFO entry count
busy  out  1  state != IDLE or occupancy != 0

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0, except cmd_ready=1.
  - FIFO pointers and count are 0; last_result=0; state=IDLE.
  - An in-flight command or held result is discarded.
- Push: a command enters the FIFO on an edge where cmd_valid && cmd_ready.
  - There is no bypass: a push into an empty FIFO is not popped in the same cycle.
  - cmd_ready depends only on count, never on pop in the same cycle.
- FSM states are IDLE, EXEC, WAIT_OUT.
  - IDLE: if count>0, pop the head into alu_a/alu_b/alu_sel and the tag register, then go to EXEC. If head.use_prev, alu_a <= last_result, else head.a.
  - EXEC: alu_out is combinationally valid. Set res_data <= alu_out, res_tag <= tag, last_result <= alu_out, res_valid <= 1. Go to WAIT_OUT.
  - WAIT_OUT: hold res_* stable while res_ready=0. On res_ready=1, res_valid <= 0. If count>0, pop the next command (with the same substitution rule) and go to EXEC; otherwise go to IDLE.
- Latency and throughput:
  - Command accepted at edge E0 -> popped at E1 -> res_valid high from E2.
  - Sustained throughput is one result per 2 cycles.
  - res_valid is low for exactly one cycle between back-to-back results.
- Push and pop in the same cycle: count is unchanged and pointers advance independently. Pointers wrap modulo DEPTH.
- Full condition: cmd_ready=0 when count==DEPTH. With res_ready held low, DEPTH+1 commands are absorbed (one in the result register, DEPTH in the FIFO).
- Chaining:
  - last_result holds the most recently captured result, in command order.
  - A use_prev command immediately following another sees that command's result, because the pop happens after capture.
- Arithmetic: the block performs no arithmetic. Operands pass through bit-exact; signedness is a property of the sel encoding only.
- alu_a/alu_b/alu_sel keep their last values when idle; they are not cleared.

Decomposition:
- alu_pkg holds:
  - sel constants: ALU_ADD=0, ALU_ADDU=1, ALU_SUB=2, ALU_SUBU=3, ALU_AND=4, ALU_OR=5, ALU_SRA=6, ALU_SRL=7
  - FSM state encoding (IDLE=0, EXEC=1, WAIT_OUT=2)
  - the command-record layout {use_prev, tag, sel, b, a}
- Sub-module cmd_fifo: synchronous FIFO with parameters DEPTH and data width, count output, and the same clk/rst_n.
- The FSM and result register live in the top level.

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release -> cmd_ready=1, res_valid=0, occupancy=0, busy=0.
2. Push a=10, b=0xFFFFFFFE, sel=0, tag=3 at E0 (ALU instantiated) -> alu_sel=0 after E1; res_valid=1 after E2 with res_data=8, res_tag=3.
3. Chain, res_ready=1:
   - Push a=10, b=2, sel=2 -> res_data=8.
   - Then push use_prev=1, a=0xDEAD, b=1, sel=7 -> res_data=4 (a ignored).
4. Backpressure: res_ready=0, push tags 0..5 continuously -> tags 0..4 accepted, cmd_ready=0 while tag 5 is offered, occupancy=4. Then res_ready=1 -> tags 0..4 then 5 delivered in order, one per 2 cycles.
5. Simultaneous push and pop at full: release one result while pushing -> occupancy stays 4 and cmd_ready stays 0. Pointer wrap is checked across 3 full refills.
6. Reset mid-flight:
   - Drop rst_n while res_valid=1 and occupancy=3 -> res_valid=0 and occupancy=0 immediately, without waiting for a clock edge.
   - After release, push use_prev=1, b=5, sel=1 -> res_data=5 (last_result was cleared to 0).
